// File: rtl/systolic_sequencer.sv
// systolic_sequencer: runs one matrix-multiply pass through an N x N
// systolic MAC array. It clears the accumulators, streams K operand
// columns/rows from a one-cycle-latency buffer and skews each lane
// diagonally. It then drains the array pipeline and pulses done.
module systolic_sequencer #(
    parameter int N          = 16,
    parameter int OP_WIDTH   = 8,
    parameter int KMAX       = 256,
    parameter int K_WIDTH    = 9,
    parameter int ADDR_WIDTH = 8,
    parameter int MAC_LAT    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [K_WIDTH-1:0]      k_len,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [N*OP_WIDTH-1:0]   a_col_data,
    input  logic [N*OP_WIDTH-1:0]   b_row_data,
    output logic                    array_clear,
    output logic [N*OP_WIDTH-1:0]   array_a_column,
    output logic [N*OP_WIDTH-1:0]   array_b_row
);

    // Drain covers skew depth N, array propagation N-1, the input register
    // and the MAC latency.
    localparam int D     = 2 * N + MAC_LAT;
    localparam int D_W   = $clog2(D + 1);
    localparam int CNT_W = (K_WIDTH > D_W) ? K_WIDTH : D_W;
    localparam logic [K_WIDTH-1:0] KMAX_V = K_WIDTH'(KMAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [K_WIDTH-1:0]     kl_q, kl_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic                   clear_q, clear_d;
    logic                   valid_q, valid_d;
    logic [K_WIDTH-1:0]     k_clamped;

    assign k_clamped = (k_len > KMAX_V) ? KMAX_V : k_len;

    // State, latched K, cycle counter and all registered control outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            kl_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            clear_q   <= 1'b1;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            kl_q      <= kl_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            clear_q   <= clear_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state logic; cnt_q counts cycles spent in FEED and DRAIN
    always_comb begin
        state_d = state_q;
        kl_d    = kl_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    kl_d    = k_clamped;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                state_d = (kl_q != '0) ? S_FEED : S_DONE;
            end
            S_FEED: begin
                if (cnt_q == CNT_W'(kl_q) - CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(D - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        rd_en_d   = (state_d == S_FEED);
        rd_addr_d = (state_d == S_FEED) ? cnt_d[ADDR_WIDTH-1:0] : '0;
        clear_d   = (state_d == S_CLEAR);
        valid_d   = rd_en_q;
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign array_clear = clear_q;

    // Lane gi gets a chain of gi+1 registers; invalid buffer data enters as 0
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [OP_WIDTH-1:0] a_sk_q [0:gi];
            logic [OP_WIDTH-1:0] a_sk_d [0:gi];
            logic [OP_WIDTH-1:0] b_sk_q [0:gi];
            logic [OP_WIDTH-1:0] b_sk_d [0:gi];

            // Shift the lane's skew chain by one stage
            always_comb begin
                a_sk_d[0] = valid_q ? a_col_data[gi*OP_WIDTH +: OP_WIDTH] : '0;
                b_sk_d[0] = valid_q ? b_row_data[gi*OP_WIDTH +: OP_WIDTH] : '0;
                for (int s = 1; s <= gi; s++) begin
                    a_sk_d[s] = a_sk_q[s-1];
                    b_sk_d[s] = b_sk_q[s-1];
                end
            end

            // Skew chain storage
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s <= gi; s++) begin
                        a_sk_q[s] <= '0;
                        b_sk_q[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s <= gi; s++) begin
                        a_sk_q[s] <= a_sk_d[s];
                        b_sk_q[s] <= b_sk_d[s];
                    end
                end
            end

            assign array_a_column[gi*OP_WIDTH +: OP_WIDTH] = a_sk_q[gi];
            assign array_b_row[gi*OP_WIDTH +: OP_WIDTH]    = b_sk_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: directed bench for systolic_sequencer (N=4).
// A buffer model answers reads one cycle later. Each read pushes its element
// into a scoreboard, which predicts the skewed array inputs cycle by cycle.
module tb_systolic_sequencer;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int KMAX    = 256;
    localparam int KW      = 9;
    localparam int AW      = 8;
    localparam int MAC_LAT = 1;
    localparam int D       = 2 * N + MAC_LAT;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              busy, done, rd_en, array_clear;
    logic [AW-1:0]     rd_addr;
    logic [N*W-1:0]    a_col_data, b_row_data;
    logic [N*W-1:0]    array_a_column, array_b_row;

    systolic_sequencer #(
        .N(N), .OP_WIDTH(W), .KMAX(KMAX), .K_WIDTH(KW),
        .ADDR_WIDTH(AW), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .a_col_data(a_col_data), .b_row_data(b_row_data),
        .array_clear(array_clear), .array_a_column(array_a_column),
        .array_b_row(array_b_row)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_k = 0;
    int rd_cnt = 0;
    bit prev_rd = 1'b0;
    int prev_addr = 0;

    typedef struct {
        int s;
        int k;
    } ent_t;
    ent_t sb[$];

    localparam logic [N*W-1:0] GARBAGE = {N{8'hA5}};

    function automatic logic [W-1:0] val_a(input int k, input int i);
        return W'(16 * k + i);
    endfunction

    function automatic logic [W-1:0] val_b(input int k, input int j);
        return W'(64 + 16 * k + j);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One cycle: sample at the falling edge, check the array against the
    // scoreboard, record reads and present buffer data for last cycle's read.
    task automatic step();
        logic [N*W-1:0] ea, eb;
        int lane;
        @(negedge clk);
        cyc++;
        ea = '0;
        eb = '0;
        foreach (sb[e]) begin
            lane = cyc - sb[e].s;
            if (lane >= 0 && lane < N) begin
                ea[lane*W +: W] = val_a(sb[e].k, lane);
                eb[lane*W +: W] = val_b(sb[e].k, lane);
            end
        end
        chk("array_a_column", array_a_column, ea);
        chk("array_b_row", array_b_row, eb);
        while (sb.size() > 0 && sb[0].s + N - 1 <= cyc) void'(sb.pop_front());
        if (rd_en === 1'b1) begin
            chk("rd_addr", rd_addr, exp_k);
            sb.push_back('{cyc + 2, exp_k});
            exp_k++;
            rd_cnt++;
        end
        if (prev_rd) begin
            for (int i = 0; i < N; i++) begin
                a_col_data[i*W +: W] = val_a(prev_addr, i);
                b_row_data[i*W +: W] = val_b(prev_addr, i);
            end
        end else begin
            a_col_data = GARBAGE;
            b_row_data = GARBAGE;
        end
        prev_rd   = (rd_en === 1'b1);
        prev_addr = int'(rd_addr);
    endtask

    // Run one pass from IDLE; returns at the first observed non-busy cycle
    task automatic run_pass(input int kreq, input bit hold, input string tag);
        int kl, busy_len, done_cnt, exp_busy;
        bit last_done;
        kl       = (kreq > KMAX) ? KMAX : kreq;
        exp_busy = (kl > 0) ? (2 + kl + D) : 2;
        k_len    = KW'(kreq);
        start    = 1'b1;
        exp_k    = 0;
        rd_cnt   = 0;
        busy_len = 0;
        done_cnt = 0;
        last_done = 1'b0;
        step();
        chk({tag, "_busy_rise"}, busy, 1'b1);
        chk({tag, "_clear_first"}, array_clear, 1'b1);
        if (!hold) start = 1'b0;
        k_len = KW'(kreq ^ 5);
        while (busy === 1'b1 && busy_len < 2000) begin
            busy_len++;
            last_done = (done === 1'b1);
            if (done === 1'b1) done_cnt++;
            step();
        end
        chk({tag, "_busy_cycles"}, busy_len, exp_busy);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_last"}, last_done, 1'b1);
        chk({tag, "_rd_count"}, rd_cnt, kl);
        chk({tag, "_done_low_idle"}, done, 1'b0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b1;
        k_len      = KW'(4);
        a_col_data = GARBAGE;
        b_row_data = GARBAGE;

        // Reset held with start asserted
        repeat (3) begin
            step();
            chk("rst_busy", busy, 1'b0);
            chk("rst_done", done, 1'b0);
            chk("rst_rd_en", rd_en, 1'b0);
            chk("rst_clear", array_clear, 1'b1);
        end
        reset = 1'b1;
        start = 1'b0;
        step();
        chk("clear_drop", array_clear, 1'b0);
        chk("idle_busy0", busy, 1'b0);
        repeat (2) step();
        chk("idle_busy1", busy, 1'b0);

        // Normal pass, then empty pass
        run_pass(4, 1'b0, "k4");
        step();
        run_pass(0, 1'b0, "k0");
        step();

        // start held through a pass: only one idle cycle between passes
        run_pass(2, 1'b1, "hold1");
        chk("hold_gap_low", busy, 1'b0);
        run_pass(2, 1'b0, "hold2");
        step();

        // Asynchronous reset at FEED cycle 2
        k_len = KW'(4);
        start = 1'b1;
        exp_k = 0;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("feed2_addr", rd_addr, 2);
        reset = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_rd_en", rd_en, 1'b0);
        chk("arst_rd_addr", rd_addr, 0);
        chk("arst_clear", array_clear, 1'b1);
        chk("arst_a", array_a_column, 0);
        chk("arst_b", array_b_row, 0);
        sb.delete();
        prev_rd = 1'b0;
        repeat (2) begin
            step();
            chk("arst_no_done", done, 1'b0);
            chk("arst_hold_busy", busy, 1'b0);
        end
        reset = 1'b1;
        step();
        chk("arst_clear_drop", array_clear, 1'b0);
        run_pass(4, 1'b0, "after_rst");
        step();

        // k_len above KMAX is clamped
        run_pass(300, 1'b0, "clamp");
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
